// File: rtl/decimal_to_binary.sv
// decimal_to_binary
//   Sequential 6-digit packed-BCD to N-bit binary converter using reverse
//   double-dabble (shift right, then subtract 3 from every BCD nibble >= 8).
//   One shift per clock; a conversion takes N edges after the start edge.
//
// Parameters
//   N          binary result width and number of shift iterations (4..24)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      conversion request, sampled only while idle
//   bcd_in     packed BCD input, digit k at [4k+3:4k], digit 5 most significant
//   busy       conversion in progress
//   done       one-cycle pulse; binary/overflow/digit_err valid from this cycle
//   binary     converted value, held until the next done
//   overflow   value did not fit in N bits
//   digit_err  some input nibble was above 9
//
// Build option
//   DTB_DIGIT_CHECK_EN  when defined, digit_err flags invalid BCD nibbles;
//                       otherwise digit_err is tied low.

module decimal_to_binary #(
  parameter int unsigned N = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [23:0]  bcd_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] binary,
  output logic         overflow,
  output logic         digit_err
);

  localparam int unsigned CW = 5;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e         state_q, state_d;
  logic [23:0]    bcd_q, bcd_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   binary_q, binary_d;
  logic           overflow_q, overflow_d;
  logic           done_q, done_d;

  logic [23:0]    bcd_sh, bcd_fix;
  logic [N-1:0]   acc_sh;
  logic           last_iter;

  assign last_iter = (cnt_q == CW'(1));

  // One reverse double-dabble iteration on the working register {bcd, acc}.
  always_comb begin
    bcd_sh  = {1'b0, bcd_q[23:1]};
    acc_sh  = {bcd_q[0], acc_q[N-1:1]};
    bcd_fix = bcd_sh;
    for (int unsigned k = 0; k < 6; k++) begin
      if (bcd_sh[4*k+3]) begin
        bcd_fix[4*k +: 4] = bcd_sh[4*k +: 4] - 4'd3;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = SHIFT;
      SHIFT:   if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    bcd_d      = bcd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    binary_d   = binary_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d = bcd_in;
          acc_d = '0;
          cnt_d = CW'(N);
        end
      end
      SHIFT: begin
        bcd_d = bcd_fix;
        acc_d = acc_sh;
        cnt_d = cnt_q - CW'(1);
        if (last_iter) begin
          binary_d   = acc_sh;
          // Any residual BCD after the last iteration is value >> N.
          overflow_d = |bcd_fix;
          done_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      binary_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      bcd_q      <= bcd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      binary_q   <= binary_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

`ifdef DTB_DIGIT_CHECK_EN
  logic bad_digit;
  logic err_pend_q, err_pend_d;
  logic digit_err_q, digit_err_d;

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned k = 0; k < 6; k++) begin
      if (bcd_in[4*k +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Flag captured at the start edge, published together with done.
  always_comb begin
    err_pend_d  = err_pend_q;
    digit_err_d = digit_err_q;
    if (state_q == IDLE && start) err_pend_d = bad_digit;
    if (state_q == SHIFT && last_iter) digit_err_d = err_pend_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pend_q  <= 1'b0;
      digit_err_q <= 1'b0;
    end else begin
      err_pend_q  <= err_pend_d;
      digit_err_q <= digit_err_d;
    end
  end

  assign digit_err = digit_err_q;
`else
  assign digit_err = 1'b0;
`endif

  // Outputs
  always_comb begin
    busy     = (state_q == SHIFT);
    done     = done_q;
    binary   = binary_q;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_decimal_to_binary.sv
module tb_decimal_to_binary;

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b;
  logic [23:0] bcd_a, bcd_b;
  logic        busy_a, done_a, ovf_a, derr_a;
  logic        busy_b, done_b, ovf_b, derr_b;
  logic [19:0] bin_a;
  logic [15:0] bin_b;

  int errors = 0;
  int checks = 0;

  decimal_to_binary #(.N(20)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bcd_in(bcd_a),
    .busy(busy_a), .done(done_a), .binary(bin_a), .overflow(ovf_a),
    .digit_err(derr_a)
  );

  decimal_to_binary #(.N(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bcd_in(bcd_b),
    .busy(busy_b), .done(done_b), .binary(bin_b), .overflow(ovf_b),
    .digit_err(derr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on dut_a for one edge (the start-sampling edge E0).
  task automatic go_a(input logic [23:0] v);
    bcd_a = v;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic go_b(input logic [23:0] v);
    bcd_b = v;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
  endtask

  // Edges after E0 until done; gives up after a fixed budget.
  task automatic wait_a(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = busy_a ? 1 : 0;
    while (!done_a && cyc < 60) begin
      tick();
      cyc++;
      if (busy_a) busy_cnt++;
    end
  endtask

  task automatic wait_b(output int cyc);
    cyc = 0;
    while (!done_b && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  int    cyc, bc, seen;
  logic  exp_derr;

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    bcd_a = '0; bcd_b = '0;
    tick(); tick();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_binary", bin_a, 0);
    chk("rst_overflow", ovf_a, 0);
    chk("rst_digit_err", derr_a, 0);
    rst_n = 1'b1;
    tick();

    // Largest 6-digit value
    go_a(24'h999999);
    chk("max_busy_e0", busy_a, 1);
    chk("max_done_e0", done_a, 0);
    wait_a(cyc, bc);
    chk("max_latency", cyc, 20);
    chk("max_busy_cycles", bc, 20);
    chk("max_binary", bin_a, 32'hF423F);
    chk("max_overflow", ovf_a, 0);
    chk("max_digit_err", derr_a, 0);
    chk("max_busy_at_done", busy_a, 0);
    tick();
    chk("max_done_pulse", done_a, 0);
    chk("max_binary_held", bin_a, 32'hF423F);

    // Back-to-back: second start presented in the done cycle
    go_a(24'h123456);
    wait_a(cyc, bc);
    chk("b2b_latency1", cyc, 20);
    chk("b2b_binary1", bin_a, 32'h1E240);
    go_a(24'h000000);
    chk("b2b_done_cleared", done_a, 0);
    chk("b2b_busy2", busy_a, 1);
    wait_a(cyc, bc);
    chk("b2b_gap", cyc + 1, 21);
    chk("b2b_binary2", bin_a, 0);
    tick();

    // Start during a conversion is ignored
    go_a(24'h999999);
    for (int i = 0; i < 4; i++) tick();
    bcd_a = 24'h000001;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    bcd_a = 24'h555555;
    wait_a(cyc, bc);
    chk("ign_latency", cyc + 5, 20);
    chk("ign_binary", bin_a, 32'hF423F);
    tick();
    chk("ign_no_restart", busy_a, 0);

    // N=16 overflow boundary
    go_b(24'h070000);
    wait_b(cyc);
    chk("n16_latency", cyc, 16);
    chk("n16_overflow", ovf_b, 1);
    tick();
    go_b(24'h065535);
    wait_b(cyc);
    chk("n16_binary_max", bin_b, 32'hFFFF);
    chk("n16_overflow_max", ovf_b, 0);
    tick();

    // Invalid BCD nibble
`ifdef DTB_DIGIT_CHECK_EN
    exp_derr = 1'b1;
`else
    exp_derr = 1'b0;
`endif
    go_a(24'h12A456);
    wait_a(cyc, bc);
    chk("derr_latency", cyc, 20);
    chk("derr_flag", derr_a, exp_derr);
    tick();

    // Reset in the middle of a conversion
    go_a(24'h999999);
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_binary", bin_a, 0);
    chk("abort_digit_err", derr_a, 0);
    tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done_a || busy_a) seen++;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_binary_after", bin_a, 0);

    go_a(24'h000042);
    wait_a(cyc, bc);
    chk("post_latency", cyc, 20);
    chk("post_binary", bin_a, 32'h2A);
    chk("post_overflow", ovf_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
